spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
Synthesizable SPI-mode-0 master that fetches 32-bit words from the external QSPI flash holding firmware, used single-bit (dq_0 = MOSI, dq_1 = MISO).
Sits between the core's boot/instruction-fetch path (valid/ready request/response) and the io_qspi_* board pins that drive the flash model in simulation.
Issues the standard READ command (0x03) with a 24-bit address, shifts in 4 bytes, and returns them little-endian.

Parameters:
CLOCK_DIV, 4, clock cycles per SCLK half-period; legal range ≥1.
ADDR_WIDTH, 24, flash byte-address width, fixed by the READ command format.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  1  read request valid
req_ready  out  1  request accepted when req_valid && req_ready at a clock edge
req_addr  in  24  flash byte address; any alignment allowed
resp_valid  out  1  read data valid
resp_ready  in  1  consumer accepts resp_data
resp_data  out  32  little-endian word: first byte received goes in [7:0]
spi_sclk  out  1  SPI clock; idles low
spi_cs  out  1  chip select, active-low
spi_mosi  out  1  master out
spi_miso  in  1  master in

Behaviour:
- Reset values: spi_cs=1, spi_sclk=0, spi_mosi=0, resp_valid=0, resp_data=0, state IDLE. req_ready=1 in the first cycle after reset.
- Only one transaction outstanding. req_ready=1 only in IDLE.
- States:
  - IDLE: on accept, latch frame {8'h03, req_addr, 32'h0} into a 64-bit shift register, go to SHIFT.
  - SHIFT: spi_cs=0. The first cycle after accept drives spi_mosi = frame[63].
  - Each bit takes CLOCK_DIV cycles with sclk low, then CLOCK_DIV cycles with sclk high.
  - On the rising sclk edge, sample spi_miso into the receive register.
  - On the falling edge, shift and present the next MOSI bit.
  - Bits 0–31 on the wire are command and address, MSB first. Bits 32–63 are data; MISO is ignored during bits 0–31. During data bits MOSI=0.
  - After the 64th falling edge: spi_cs=1, spi_sclk=0, resp_valid=1, go to RESP.
  - RESP: hold resp_data and resp_valid until resp_ready. Then go to GAP.
  - GAP: spi_cs stays high for CLOCK_DIV cycles, then return to IDLE.
- Byte order: within each byte the MSB arrives first. Byte k (k=0..3, in arrival order) maps to resp_data[8k+7:8k].
- Latency: accept at edge T gives resp_valid high from cycle T+1+128*CLOCK_DIV (513 cycles for CLOCK_DIV=4).
- resp_valid && resp_ready in the same cycle that resp_valid first rises is legal; the response completes in that cycle.
- Address wrap: 24-bit address sent as-is; flash-side wrap is the device's concern.
- Reset mid-frame: next edge forces spi_cs=1, spi_sclk=0, spi_mosi=0 and drops any partial data. No resp_valid is generated for the aborted request.
- req_valid while busy: ignored, not latched. The requester must hold it until ready.
- SCLK divider counter: width $clog2(CLOCK_DIV)+1, reset to 0 on each accept.

Decomposition:
- Shared package spi_flash_pkg holds:
  - CMD_READ = 8'h03
  - FRAME_BITS = 64
  - DATA_BITS = 32
  - state typedef enum {IDLE, SHIFT, RESP, GAP}
- One sub-module, spi_clock_gen:
  - Divider producing spi_sclk plus single-cycle rise_strobe and fall_strobe.
  - Enabled while in SHIFT; cleared on accept and on reset.
- Top-level holds the FSM, shift registers and bit counter (0..63).

Test Plan:
- Flash preloaded with byte i = i (0x00..0xFF). CLOCK_DIV=4, read addr 0x000000.
  - Expect resp_data=0x03020100, resp_valid at T+513.
  - MOSI carries 0x03,0x00,0x00,0x00 across the first 32 rising edges.
- Unaligned read at addr 0x000005 -> resp_data=0x08070605.
- Back-pressure: resp_ready=0 for 20 cycles.
  - resp_data and resp_valid remain stable; req_ready=0; spi_cs=1 throughout.
  - Then resp_ready=1 for one cycle, followed by exactly CLOCK_DIV cycles of GAP before req_ready=1.
- Back-to-back reads of 0x10 and 0x14 -> 0x13121110 then 0x17161514. spi_cs is high for ≥CLOCK_DIV cycles between frames.
- Reset asserted for 1 cycle at bit 20 of a read.
  - Next cycle: spi_cs=1, spi_sclk=0, no resp_valid.
  - A following read of 0x20 -> 0x23222120.
- CLOCK_DIV=1 build, read addr 0x40.
  - resp_data=0x43424140, latency 129 cycles.
  - spi_sclk toggles every cycle during SHIFT.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants, FSM state type and byte-order helper for the SPI flash reader.
package spi_flash_pkg;

  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned DATA_BITS  = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, RESP, GAP} state_e;

  // Bytes arrive MSB-first into a shift register; the first byte must land in [7:0].
  function automatic logic [31:0] bytes_le(input logic [31:0] arrival);
    return {arrival[7:0], arrival[15:8], arrival[23:16], arrival[31:24]};
  endfunction

endpackage

// File: rtl/spi_clock_gen.sv
// SCLK divider: CLOCK_DIV cycles per half-period, idles low, with single-cycle edge strobes.
module spi_clock_gen #(
  parameter int unsigned CLOCK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic sclk_o,
  output logic rise_strobe_o,
  output logic fall_strobe_o
);

  localparam int unsigned CW = $clog2(CLOCK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

  logic [CW-1:0] count_q;
  logic          wrap;

  // Strobes are high in the cycle before the edge on which sclk toggles.
  assign wrap          = enable_i && !clear_i && (count_q == LAST);
  assign rise_strobe_o = wrap && !sclk_o;
  assign fall_strobe_o = wrap && sclk_o;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      count_q <= '0;
      sclk_o  <= 1'b0;
    end else if (enable_i) begin
      if (wrap) begin
        count_q <= '0;
        sclk_o  <= ~sclk_o;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end else begin
      count_q <= '0;
      sclk_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Single-bit SPI mode-0 master issuing READ (0x03) + 24-bit address and returning
// the next four flash bytes as a little-endian word over a valid/ready interface.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLOCK_DIV  = 4,
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  spi_sclk,
  output logic                  spi_cs,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned CW = $clog2(CLOCK_DIV) + 1;
  localparam logic [CW-1:0] GAP_LAST  = CW'(CLOCK_DIV - 1);
  localparam logic [5:0]    LAST_BIT  = 6'(FRAME_BITS - 1);
  localparam logic [5:0]    FIRST_RX  = 6'(FRAME_BITS - DATA_BITS);

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  tx_q;
  logic [DATA_BITS-1:0]   rx_q;
  logic [5:0]             bit_q;
  logic [CW-1:0]          gap_q;
  logic                   cs_q;
  logic                   valid_q;
  logic                   ready_q;
  logic [31:0]            data_q;

  logic                   accept;
  logic                   rise;
  logic                   fall;
  logic [FRAME_BITS-1:0]  frame;

  assign accept = req_valid && ready_q;
  assign frame  = {CMD_READ, req_addr, {DATA_BITS{1'b0}}};

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign spi_cs     = cs_q;
  // The low half of the frame is zero, so MOSI is naturally 0 during data bits.
  assign spi_mosi   = tx_q[FRAME_BITS-1];

  spi_clock_gen #(
    .CLOCK_DIV(CLOCK_DIV)
  ) u_clock_gen (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (accept),
    .enable_i     (state_q == SHIFT),
    .sclk_o       (spi_sclk),
    .rise_strobe_o(rise),
    .fall_strobe_o(fall)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b1;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            tx_q    <= frame;
            rx_q    <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise && bit_q >= FIRST_RX) begin
            rx_q <= {rx_q[DATA_BITS-2:0], spi_miso};
          end
          if (fall) begin
            if (bit_q == LAST_BIT) begin
              tx_q    <= '0;
              cs_q    <= 1'b1;
              valid_q <= 1'b1;
              data_q  <= bytes_le(rx_q);
              state_q <= RESP;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= {tx_q[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a CLOCK_DIV=4 and a CLOCK_DIV=1 instance share a flash image,
// a timeline model predicts every output each cycle, and literal checks pin the model.
module tb_spi_flash_reader;

  logic        clock;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [23:0] req_addr   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data  [2];
  logic        spi_sclk   [2];
  logic        spi_cs     [2];
  logic        spi_mosi   [2];
  logic        spi_miso   [2];

  logic [7:0]  mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_flash_reader #(
      .CLOCK_DIV (g == 0 ? 4 : 1),
      .ADDR_WIDTH(24)
    ) u_dut (
      .clock     (clock),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_data (resp_data[g]),
      .spi_sclk  (spi_sclk[g]),
      .spi_cs    (spi_cs[g]),
      .spi_mosi  (spi_mosi[g]),
      .spi_miso  (spi_miso[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h, expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input int inst, input logic act, input logic exp);
    check(name, inst, {31'd0, act}, {31'd0, exp});
  endtask

  // Timeline model: phase 0 idle, 1 frame (j cycles since accept), 2 response, 3 gap.
  int          m_phase [2];
  int          m_j     [2];
  int          m_g     [2];
  bit          m_on    [2];
  logic [23:0] m_addr  [2];
  logic [31:0] m_exp   [2];

  // Flash device model state, sampled mid-cycle.
  int          f_bit   [2];
  logic [31:0] f_sr    [2];
  bit          f_prev  [2];

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      int          d;
      int          k;
      logic [7:0]  idx;
      logic [7:0]  a0;
      logic [63:0] fr;
      d = div_of(i);

      // Flash: capture command/address on rising SCLK, present data after falling SCLK.
      if (spi_cs[i] !== 1'b0) begin
        f_bit[i]    = 0;
        spi_miso[i] = 1'b0;
      end else if (spi_sclk[i] === 1'b1 && !f_prev[i]) begin
        if (f_bit[i] < 32) f_sr[i] = {f_sr[i][30:0], spi_mosi[i]};
        f_bit[i]++;
        if (f_bit[i] == 32) begin
          check("wire_cmd", i, {24'd0, f_sr[i][31:24]}, 32'h03);
          check("wire_addr", i, {8'd0, f_sr[i][23:0]}, {8'd0, m_addr[i]});
        end
      end else if (spi_sclk[i] === 1'b0 && f_prev[i] && f_bit[i] >= 32 && f_bit[i] < 64) begin
        k           = f_bit[i] - 32;
        idx         = f_sr[i][7:0] + 8'(k / 8);
        spi_miso[i] = mem[idx][7 - (k % 8)];
      end
      f_prev[i] = (spi_sclk[i] === 1'b1);

      // Compare outputs after the last edge against the model.
      if (m_on[i]) begin
        case (m_phase[i])
          0: begin
            check_bit("idle_ready", i, req_ready[i], 1'b1);
            check_bit("idle_cs", i, spi_cs[i], 1'b1);
            check_bit("idle_sclk", i, spi_sclk[i], 1'b0);
            check_bit("idle_valid", i, resp_valid[i], 1'b0);
          end
          1: begin
            fr = {8'h03, m_addr[i], 32'h0};
            check_bit("frame_ready", i, req_ready[i], 1'b0);
            check_bit("frame_cs", i, spi_cs[i], 1'b0);
            check_bit("frame_sclk", i, spi_sclk[i], ((m_j[i] / d) % 2) == 1);
            check_bit("frame_mosi", i, spi_mosi[i], fr[63 - m_j[i] / (2 * d)]);
            check_bit("frame_valid", i, resp_valid[i], 1'b0);
          end
          2: begin
            check_bit("resp_ready_out", i, req_ready[i], 1'b0);
            check_bit("resp_cs", i, spi_cs[i], 1'b1);
            check_bit("resp_sclk", i, spi_sclk[i], 1'b0);
            check_bit("resp_valid", i, resp_valid[i], 1'b1);
            check("resp_data", i, resp_data[i], m_exp[i]);
          end
          default: begin
            check_bit("gap_ready", i, req_ready[i], 1'b0);
            check_bit("gap_cs", i, spi_cs[i], 1'b1);
            check_bit("gap_sclk", i, spi_sclk[i], 1'b0);
            check_bit("gap_valid", i, resp_valid[i], 1'b0);
          end
        endcase
      end

      // Advance the model to the state after the coming edge.
      if (reset[i]) begin
        m_on[i]    = 1'b1;
        m_phase[i] = 0;
      end else if (m_on[i]) begin
        case (m_phase[i])
          0: if (req_valid[i]) begin
            m_phase[i] = 1;
            m_j[i]     = 0;
            m_addr[i]  = req_addr[i];
            a0         = req_addr[i][7:0];
            m_exp[i]   = {mem[8'(a0 + 8'd3)], mem[8'(a0 + 8'd2)], mem[8'(a0 + 8'd1)], mem[a0]};
          end
          1: begin
            m_j[i]++;
            if (m_j[i] == 128 * d) m_phase[i] = 2;
          end
          2: if (resp_ready[i]) begin
            m_phase[i] = 3;
            m_g[i]     = 0;
          end
          default: begin
            m_g[i]++;
            if (m_g[i] == d) m_phase[i] = 0;
          end
        endcase
      end
    end
  end

  // Request, wait for the response, hold off resp_ready for `hold` cycles, then measure the gap.
  task automatic do_read(input int i, input logic [23:0] a, input int hold,
                         output logic [31:0] data, output int lat, output int gap);
    int n;
    data = '0;
    lat  = 0;
    gap  = 0;
    req_addr[i]  = a;
    req_valid[i] = 1'b1;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 2000) begin
      check("accept_timeout", i, 32'd0, 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
    if (hold == 0) resp_ready[i] = 1'b1;
    while (resp_valid[i] !== 1'b1 && lat < 2000) begin
      @(posedge clock); #1;
      lat++;
    end
    if (lat >= 2000) begin
      check("resp_timeout", i, 32'd0, 32'd1);
      resp_ready[i] = 1'b0;
      return;
    end
    lat  = lat + 1;
    data = resp_data[i];
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
    end
    resp_ready[i] = 1'b1;
    @(posedge clock); #1;
    resp_ready[i] = 1'b0;
    while (req_ready[i] !== 1'b1 && gap < 100) begin
      @(posedge clock); #1;
      gap++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    int          gap;
    for (int i = 0; i < 2; i++) begin
      reset[i]      = 1'b1;
      req_valid[i]  = 1'b0;
      req_addr[i]   = '0;
      resp_ready[i] = 1'b0;
    end
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    repeat (3) @(posedge clock);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    check_bit("reset_ready", 0, req_ready[0], 1'b1);
    check_bit("reset_cs", 0, spi_cs[0], 1'b1);
    check_bit("reset_sclk", 0, spi_sclk[0], 1'b0);
    check_bit("reset_mosi", 0, spi_mosi[0], 1'b0);
    check("reset_data", 0, resp_data[0], 32'h0);

    do_read(0, 24'h000000, 0, d, lat, gap);
    check("read0_data", 0, d, 32'h03020100);
    check("read0_latency", 0, lat, 513);

    do_read(0, 24'h000005, 1, d, lat, gap);
    check("unaligned_data", 0, d, 32'h08070605);

    do_read(0, 24'h000010, 20, d, lat, gap);
    check("stall_data", 0, d, 32'h13121110);
    check("stall_gap", 0, gap, 4);
    do_read(0, 24'h000014, 0, d, lat, gap);
    check("b2b_data", 0, d, 32'h17161514);

    // Abort during bit 20 (cycles 160..167 after accept).
    req_addr[0]  = 24'h000030;
    req_valid[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    repeat (162) @(posedge clock);
    #1;
    check_bit("pre_abort_cs", 0, spi_cs[0], 1'b0);
    reset[0] = 1'b1;
    @(posedge clock); #1;
    reset[0] = 1'b0;
    check_bit("abort_cs", 0, spi_cs[0], 1'b1);
    check_bit("abort_sclk", 0, spi_sclk[0], 1'b0);
    check_bit("abort_valid", 0, resp_valid[0], 1'b0);
    repeat (600) @(posedge clock);
    #1;
    do_read(0, 24'h000020, 2, d, lat, gap);
    check("after_abort_data", 0, d, 32'h23222120);

    do_read(1, 24'h000040, 0, d, lat, gap);
    check("div1_data", 1, d, 32'h43424140);
    check("div1_latency", 1, lat, 129);
    check("div1_gap", 1, gap, 1);

    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    for (int r = 0; r < 16; r++) begin
      int i;
      i = (r % 4 == 0) ? 0 : 1;
      do_read(i, 24'($urandom), int'($urandom_range(0, 4)), d, lat, gap);
      check("rand_latency", i, lat, 128 * div_of(i) + 1);
      check("rand_gap", i, gap, div_of(i));
    end

    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
